// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC sensor readers.
package tdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        DRAIN
    } tdc_state_e;

    localparam int DEF_LEN   = 32;
    localparam int DEF_DEPTH = 256;
    localparam int DEF_PRE   = 32;

    // Width of a propagation-depth code able to hold 0..len.
    function automatic int W(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/tdc_therm_encoder.sv
// Two-stage pipelined popcount of a TDC tap vector: half sums, then total.
// Counting ones rather than locating the first edge makes the code
// insensitive to bubbles in the thermometer.
module tdc_therm_encoder
    import tdc_pkg::*;
#(
    parameter int g_LEN = DEF_LEN
) (
    input  logic                   clkSample,
    input  logic                   rst_n,
    input  logic [g_LEN-1:0]       taps_i,
    output logic [W(g_LEN)-1:0]    code_o
);

    localparam int CW = W(g_LEN);
    localparam int LO = g_LEN / 2;
    localparam int HI = g_LEN - LO;
    localparam int HW = W(HI);

    logic [HW-1:0] lo_d, lo_q, hi_d, hi_q;
    logic [CW-1:0] code_d, code_q;

    // Count ones in each half of the tap vector.
    always_comb begin
        lo_d = '0;
        hi_d = '0;
        for (int i = 0; i < LO; i++) lo_d = lo_d + HW'(taps_i[i]);
        for (int i = LO; i < g_LEN; i++) hi_d = hi_d + HW'(taps_i[i]);
        code_d = CW'(lo_q) + CW'(hi_q);
    end

    // Pipeline registers: half sums at stage one, full code at stage two.
    always_ff @(posedge clkSample or negedge rst_n) begin
        if (!rst_n) begin
            lo_q   <= '0;
            hi_q   <= '0;
            code_q <= '0;
        end else begin
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            code_q <= code_d;
        end
    end

    assign code_o = code_q;

endmodule

// File: rtl/tdc_trace_capture.sv
// Trace capture around an activity trigger: encodes every sample, keeps a
// pre-trigger history in a circular RAM and drains the frozen trace
// oldest-first over a valid/ready stream.
module tdc_trace_capture
    import tdc_pkg::*;
#(
    parameter int g_LEN   = DEF_LEN,
    parameter int g_DEPTH = DEF_DEPTH,
    parameter int g_PRE   = DEF_PRE
) (
    input  logic                        clkSample,
    input  logic                        rst_n,
    input  logic [g_LEN-1:0]            clkProp,
    input  logic                        arm,
    input  logic                        trig_in,
    output logic [W(g_LEN)-1:0]         out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic [$clog2(g_DEPTH)-1:0]  trig_idx
);

    localparam int CW = W(g_LEN);
    localparam int AW = $clog2(g_DEPTH);
    localparam logic [AW-1:0] PRE_C   = AW'(g_PRE);
    localparam logic [AW-1:0] POST_C  = AW'(g_DEPTH - g_PRE - 1);
    localparam logic [AW:0]   RC_FULL = (AW + 1)'(g_DEPTH);
    localparam logic [AW:0]   RC_LAST = (AW + 1)'(g_DEPTH - 1);

    tdc_state_e     state_q, state_d;
    logic [AW-1:0]  wp_q, wp_d;
    logic [AW-1:0]  fc_q, fc_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [AW-1:0]  rp_q, rp_d;
    logic [AW:0]    rc_q, rc_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic           sync1_q, sync2_q, sync3_q;
    logic [AW-1:0]  trig_idx_q;
    logic [CW-1:0]  rdata_q;
    logic [CW-1:0]  code;
    logic           wr_en, rd_en, trig_edge;

    logic [CW-1:0]  mem [g_DEPTH];

    tdc_therm_encoder #(.g_LEN(g_LEN)) u_enc (
        .clkSample (clkSample),
        .rst_n     (rst_n),
        .taps_i    (clProp_unused_guard(clkProp)),
        .code_o    (code)
    );

    function automatic logic [g_LEN-1:0] clProp_unused_guard(input logic [g_LEN-1:0] v);
        return v;
    endfunction

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge clkSample or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= trig_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign trig_edge = sync2_q & ~sync3_q;

    // Capture sequencing; the read pointer is loaded with the trace start at
    // the trigger so no separate start register is needed.
    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        fc_d    = fc_q;
        pc_d    = pc_q;
        rp_d    = rp_q;
        rc_d    = rc_q;
        valid_d = valid_q;
        last_d  = last_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = PRE;
                    wp_d    = '0;
                    fc_d    = '0;
                end
            end
            PRE: begin
                if (arm) begin
                    wp_d = '0;
                    fc_d = '0;
                end else begin
                    wr_en = 1'b1;
                    wp_d  = wp_q + 1'b1;
                    fc_d  = (fc_q == PRE_C) ? fc_q : fc_q + 1'b1;
                    if (fc_d == PRE_C) state_d = ARMED;
                end
            end
            ARMED: begin
                wr_en = 1'b1;
                wp_d  = wp_q + 1'b1;
                if (trig_edge) begin
                    rp_d    = wp_q - PRE_C;
                    rc_d    = '0;
                    pc_d    = POST_C;
                    state_d = (POST_C == '0) ? DRAIN : POST;
                end
            end
            POST: begin
                if (pc_q != '0) begin
                    wr_en = 1'b1;
                    wp_d  = wp_q + 1'b1;
                    pc_d  = pc_q - 1'b1;
                end
                if (pc_q <= AW'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (valid_q && out_ready && last_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end else if ((!valid_q || out_ready) && rc_q != RC_FULL) begin
                    rd_en   = 1'b1;
                    rp_d    = rp_q + 1'b1;
                    rc_d    = rc_q + 1'b1;
                    valid_d = 1'b1;
                    last_d  = (rc_q == RC_LAST);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointers, counters and stream flags.
    always_ff @(posedge clkSample or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wp_q       <= '0;
            fc_q       <= '0;
            pc_q       <= '0;
            rp_q       <= '0;
            rc_q       <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            trig_idx_q <= PRE_C;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            fc_q       <= fc_d;
            pc_q       <= pc_d;
            rp_q       <= rp_d;
            rc_q       <= rc_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            trig_idx_q <= PRE_C;
        end
    end

    // Trace memory array, deliberately without reset.
    always_ff @(posedge clkSample) begin
        if (wr_en) mem[wp_q] <= code;
    end

    // Registered read doubling as the output holding register under stall.
    always_ff @(posedge clkSample or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[rp_q];
    end

    assign out_data  = rdata_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE);
    assign trig_idx  = trig_idx_q;

endmodule

// File: tb/tb_tdc_trace_capture.sv
// Scoreboard bench for tdc_trace_capture with a 16-deep, 4-pre trace.
module tb_tdc_trace_capture;

    localparam int LEN   = 32;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] clkProp;
    logic        arm;
    logic        trig_in;
    logic [5:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic [3:0]  trig_idx;

    int          total = 0;
    int          bad = 0;
    int          hsCount = 0;
    int          rampI = 0;
    int          curCode = 0;
    bit          rndReady = 0;
    int          hist[$];
    logic [31:0] vecQ[$];
    int          codeQ[$];
    exp_t        expQ[$];
    bit          stallPrev = 0;
    int          prevData = 0;
    int          prevLast = 0;
    exp_t        e;

    tdc_trace_capture #(.g_LEN(LEN), .g_DEPTH(DEPTH), .g_PRE(PRE)) dut (
        .clkSample (clk),
        .rst_n     (rst_n),
        .clkProp   (clkProp),
        .arm       (arm),
        .trig_in   (trig_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .trig_idx  (trig_idx)
    );

    always #5 clk = ~clk;

    // Record the hand-known code of the sample taken at every edge.
    always @(posedge clk) hist.push_back(curCode);

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Advance one cycle and drive the next sample, ready and cleared arm.
    task automatic applyStimulus();
        logic [63:0] t;
        @(posedge clk);
        #1;
        arm = 1'b0;
        out_ready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
        if (vecQ.size() > 0) begin
            clkProp = vecQ.pop_front();
            curCode = codeQ.pop_front();
        end else begin
            rampI = (rampI + 1) % 33;
            t = (64'd1 << rampI) - 64'd1;
            clkProp = t[31:0];
            curCode = rampI;
        end
    endtask

    // Raise the trigger, queue the expected trace and wait for the drain.
    task automatic captureTrace(input bit noisy, input int stopAfter);
        int k;
        int base;
        int n;
        trig_in = 1'b1;
        k = hist.size();
        for (int j = 0; j < 12; j++) begin
            applyStimulus();
            if (noisy && j == 2) trig_in = 1'b0;
            if (noisy && j == 4) trig_in = 1'b1;
            if (noisy && j == 5) arm = 1'b1;
            if (noisy && j == 6) checkOutput("busy_post", busy, 1);
        end
        base = hsCount;
        for (int j = 0; j < DEPTH; j++) expQ.push_back('{hist[k - PRE + j], (j == DEPTH - 1)});
        for (n = 0; n < 400; n++) begin
            applyStimulus();
            if (noisy && n == 3) arm = 1'b1;
            if (hsCount - base >= stopAfter) break;
        end
        if (n >= 400) checkOutput("drain_timeout", hsCount - base, stopAfter);
        if (stopAfter == DEPTH) begin
            checkOutput("valid_fall", out_valid, 0);
            checkOutput("busy_fall", busy, 0);
            checkOutput("handshakes", hsCount - base, DEPTH);
            checkOutput("queue_empty", expQ.size(), 0);
        end
    endtask

    // Monitor: compare every handshake against the scoreboard and check
    // that a stalled output holds still.
    always @(negedge clk) begin
        if (!rst_n) begin
            stallPrev = 0;
        end else begin
            if (stallPrev) begin
                checkOutput("stall_data", out_data, prevData);
                checkOutput("stall_last", out_last, prevLast);
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL extra_handshake actual data=%0d required none", out_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("trace_data@hs%0d", hsCount), out_data, e.data);
                    checkOutput($sformatf("trace_last@hs%0d", hsCount), out_last, e.last);
                end
                hsCount++;
            end
            stallPrev = out_valid && !out_ready;
            prevData  = out_data;
            prevLast  = out_last;
        end
    end

    initial begin
        int base;
        rst_n = 1'b0;
        clkProp = '0;
        arm = 1'b0;
        trig_in = 1'b0;
        out_ready = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_last", out_last, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_trig_idx", trig_idx, PRE);
        rst_n = 1'b1;
        repeat (3) applyStimulus();

        $display("[TB] basic ramp trace with ignored inputs in POST/DRAIN");
        applyStimulus();
        arm = 1'b1;
        repeat (20) applyStimulus();
        captureTrace(1, DEPTH);
        trig_in = 1'b0;

        $display("[TB] early trigger coinciding with end of pre-fill");
        repeat (4) applyStimulus();
        arm = 1'b1;
        applyStimulus();
        applyStimulus();
        trig_in = 1'b1;
        base = hsCount;
        repeat (20) applyStimulus();
        checkOutput("early_busy", busy, 1);
        checkOutput("early_no_valid", out_valid, 0);
        checkOutput("early_no_hs", hsCount - base, 0);
        trig_in = 1'b0;
        repeat (3) applyStimulus();
        captureTrace(0, DEPTH);

        $display("[TB] held trigger level gives no new capture");
        arm = 1'b1;
        base = hsCount;
        repeat (30) applyStimulus();
        checkOutput("held_busy", busy, 1);
        checkOutput("held_no_valid", out_valid, 0);
        checkOutput("held_no_hs", hsCount - base, 0);

        $display("[TB] random backpressure");
        trig_in = 1'b0;
        repeat (3) applyStimulus();
        rndReady = 1;
        captureTrace(0, DEPTH);
        rndReady = 0;

        $display("[TB] reset in the middle of the drain");
        trig_in = 1'b0;
        applyStimulus();
        arm = 1'b1;
        repeat (10) applyStimulus();
        captureTrace(0, 7);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_out_valid", out_valid, 0);
        checkOutput("rst_mid_out_last", out_last, 0);
        checkOutput("rst_mid_out_data", out_data, 0);
        checkOutput("rst_mid_busy", busy, 0);
        expQ.delete();
        trig_in = 1'b0;
        repeat (2) applyStimulus();
        rst_n = 1'b1;
        applyStimulus();

        $display("[TB] encoding vectors around the trigger after reset");
        applyStimulus();
        arm = 1'b1;
        repeat (10) applyStimulus();
        vecQ.push_back(32'h0000FFFF); codeQ.push_back(16);
        vecQ.push_back(32'hFFFFFFFF); codeQ.push_back(32);
        vecQ.push_back(32'h00000000); codeQ.push_back(0);
        vecQ.push_back(32'h0000F0FF); codeQ.push_back(12);
        applyStimulus();
        captureTrace(1, DEPTH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
